// File: rtl/reg_verifier.sv
// Post-run register self-check: gates the processor for a programmed number of
// cycles, then sweeps the regfile through read port A against an expected-value ROM.
module reg_verifier #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned CYCLE_WIDTH = 16,
  parameter int unsigned ERR_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CYCLE_WIDTH-1:0] num_cycles,
  input  logic                   verify_en,
  input  logic [ADDR_WIDTH-1:0]  proc_rs1,
  output logic [ADDR_WIDTH-1:0]  rf_rs1,
  input  logic [DATA_WIDTH-1:0]  rf_dataA,
  output logic [ADDR_WIDTH-1:0]  exp_addr,
  input  logic [DATA_WIDTH-1:0]  exp_data,
  output logic                   run_en,
  output logic                   test_mode,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_WIDTH-1:0]   error_count,
  output logic                   fail_valid,
  output logic [ADDR_WIDTH-1:0]  fail_reg,
  output logic                   chk_valid,
  output logic [ADDR_WIDTH-1:0]  chk_reg,
  output logic [DATA_WIDTH-1:0]  chk_actual,
  output logic [DATA_WIDTH-1:0]  chk_expected
);

  localparam int unsigned SCAN_WIDTH = ADDR_WIDTH + 1;
  localparam logic [SCAN_WIDTH-1:0] SCAN_LAST = SCAN_WIDTH'(NUM_REGS);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]             state_q,      state_d;
  logic [CYCLE_WIDTH-1:0] cyc_q,        cyc_d;
  logic [CYCLE_WIDTH-1:0] ncyc_q,       ncyc_d;
  logic                   ver_q,        ver_d;
  logic [SCAN_WIDTH-1:0]  scan_q,       scan_d;
  logic                   stg_valid_q,  stg_valid_d;
  logic [ADDR_WIDTH-1:0]  stg_reg_q,    stg_reg_d;
  logic [DATA_WIDTH-1:0]  stg_data_q,   stg_data_d;
  logic [ERR_WIDTH-1:0]   err_q,        err_d;
  logic                   fail_valid_q, fail_valid_d;
  logic [ADDR_WIDTH-1:0]  fail_reg_q,   fail_reg_d;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      ncyc_q       <= '0;
      ver_q        <= 1'b0;
      scan_q       <= '0;
      stg_valid_q  <= 1'b0;
      stg_reg_q    <= '0;
      stg_data_q   <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_reg_q   <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      ncyc_q       <= ncyc_d;
      ver_q        <= ver_d;
      scan_q       <= scan_d;
      stg_valid_q  <= stg_valid_d;
      stg_reg_q    <= stg_reg_d;
      stg_data_q   <= stg_data_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_reg_q   <= fail_reg_d;
    end
  end

  // Next-state: sequencing plus the compare of the staged register against ROM data
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    ncyc_d       = ncyc_q;
    ver_d        = ver_q;
    scan_d       = scan_q;
    stg_valid_d  = 1'b0;
    stg_reg_d    = stg_reg_q;
    stg_data_d   = stg_data_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_reg_d   = fail_reg_q;

    // Staged data is only valid during SCAN, so this never collides with the start clear
    if (stg_valid_q && ver_q && (exp_data != stg_data_q)) begin
      if (err_q != ERR_MAX) err_d = err_q + ERR_WIDTH'(1);
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_reg_d   = stg_reg_q;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ncyc_d       = num_cycles;
          ver_d        = verify_en;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_reg_d   = '0;
          cyc_d        = '0;
          scan_d       = '0;
          state_d      = (num_cycles == '0) ? ST_SCAN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cyc_q == ncyc_q - CYCLE_WIDTH'(1)) begin
          state_d = ST_SCAN;
          scan_d  = '0;
        end else begin
          cyc_d = cyc_q + CYCLE_WIDTH'(1);
        end
      end
      ST_SCAN: begin
        // Final SCAN cycle only drains the stage register
        if (scan_q == SCAN_LAST) begin
          state_d = ST_DONE;
        end else begin
          stg_valid_d = 1'b1;
          stg_reg_d   = ADDR_WIDTH'(scan_q);
          stg_data_d  = rf_dataA;
          scan_d      = scan_q + SCAN_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_en       = (state_q == ST_RUN);
  assign test_mode    = (state_q == ST_SCAN);
  assign busy         = (state_q == ST_RUN) || (state_q == ST_SCAN);
  assign done         = (state_q == ST_DONE);
  assign pass         = done && ver_q && (err_q == '0);
  assign error_count  = err_q;
  assign fail_valid   = fail_valid_q;
  assign fail_reg     = fail_reg_q;

  assign rf_rs1       = test_mode ? ADDR_WIDTH'(scan_q) : proc_rs1;
  assign exp_addr     = test_mode ? ADDR_WIDTH'(scan_q) : '0;

  // ROM data arrives one cycle after its address, aligned with the staged regfile value
  assign chk_valid    = stg_valid_q;
  assign chk_reg      = stg_valid_q ? stg_reg_q : '0;
  assign chk_actual   = stg_valid_q ? stg_data_q : '0;
  assign chk_expected = (stg_valid_q && ver_q) ? exp_data : '0;

endmodule

// File: tb/tb_reg_verifier.sv
// Directed-random bench for reg_verifier: arrays stand in for regfile and ROM,
// expected results are derived from the arrays after each run.
module tb_reg_verifier;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_cycles = '0;
  logic          verify_en = 1'b0;
  logic [AW-1:0] proc_rs1 = '0;

  logic [AW-1:0] rf_rs1, exp_addr, fail_reg, chk_reg;
  logic [DW-1:0] rf_dataA, exp_data, chk_actual, chk_expected;
  logic          run_en, test_mode, busy, done, pass, fail_valid, chk_valid;
  logic [7:0]    error_count;

  logic [AW-1:0] s_rf_rs1, s_exp_addr, s_fail_reg, s_chk_reg;
  logic [DW-1:0] s_rf_dataA, s_exp_data, s_chk_actual, s_chk_expected;
  logic          s_run_en, s_test_mode, s_busy, s_done, s_pass, s_fail_valid, s_chk_valid;
  logic [1:0]    s_error_count;

  logic [DW-1:0] rf  [NR];
  logic [DW-1:0] rom [NR];

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] q_reg [$];
  logic [DW-1:0] q_act [$];
  logic [DW-1:0] q_exp [$];

  reg_verifier #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .CYCLE_WIDTH(CW),
                 .ERR_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .verify_en(verify_en), .proc_rs1(proc_rs1), .rf_rs1(rf_rs1), .rf_dataA(rf_dataA),
    .exp_addr(exp_addr), .exp_data(exp_data), .run_en(run_en), .test_mode(test_mode),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .fail_valid(fail_valid), .fail_reg(fail_reg), .chk_valid(chk_valid),
    .chk_reg(chk_reg), .chk_actual(chk_actual), .chk_expected(chk_expected));

  reg_verifier #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .CYCLE_WIDTH(CW),
                 .ERR_WIDTH(2)) u_sat (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .verify_en(verify_en), .proc_rs1(proc_rs1), .rf_rs1(s_rf_rs1), .rf_dataA(s_rf_dataA),
    .exp_addr(s_exp_addr), .exp_data(s_exp_data), .run_en(s_run_en), .test_mode(s_test_mode),
    .busy(s_busy), .done(s_done), .pass(s_pass), .error_count(s_error_count),
    .fail_valid(s_fail_valid), .fail_reg(s_fail_reg), .chk_valid(s_chk_valid),
    .chk_reg(s_chk_reg), .chk_actual(s_chk_actual), .chk_expected(s_chk_expected));

  always #5 clock = ~clock;

  // Combinational regfile read, registered ROM read
  assign rf_dataA   = rf[rf_rs1];
  assign s_rf_dataA = rf[s_rf_rs1];
  always @(posedge clock) begin
    exp_data   <= rom[exp_addr];
    s_exp_data <= rom[s_exp_addr];
  end

  always @(negedge clock) begin
    if (chk_valid === 1'b1) begin
      q_reg.push_back(chk_reg);
      q_act.push_back(chk_actual);
      q_exp.push_back(chk_expected);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill_match();
    for (int i = 0; i < NR; i++) begin
      rf[i]  = $urandom;
      rom[i] = rf[i];
    end
  endtask

  // Launches one run and checks timing, strobes and results against the arrays
  task automatic run_and_check(input int n, input bit ver, input bit poke_start, input string tag);
    int cyc, runs, first_scan, cnt, first, lim;
    cnt = 0;
    first = -1;
    for (int i = 0; i < NR; i++) begin
      if (rf[i] !== rom[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    q_reg.delete(); q_act.delete(); q_exp.delete();
    num_cycles = CW'(n);
    verify_en  = ver;
    start      = 1'b1;
    @(negedge clock);
    start      = 1'b0;
    num_cycles = CW'($urandom);
    verify_en  = 1'($urandom);
    cyc = 0; runs = 0; first_scan = -1;
    while (done !== 1'b1 && cyc < 1000) begin
      if (run_en === 1'b1) runs++;
      if (test_mode === 1'b1 && first_scan < 0) first_scan = cyc;
      start = (poke_start && cyc == 2) ? 1'b1 : 1'b0;
      cyc++;
      @(negedge clock);
    end
    start = 1'b0;
    check({tag, ".done_latency"}, 64'(cyc), 64'(n + NR + 1));
    check({tag, ".run_en_cycles"}, 64'(runs), 64'(n));
    check({tag, ".scan_entry"}, 64'(first_scan), 64'(n));
    check({tag, ".strobes"}, 64'(q_reg.size()), 64'(NR));
    lim = (q_reg.size() < NR) ? q_reg.size() : NR;
    for (int i = 0; i < lim; i++) begin
      check({tag, ".chk_reg"}, 64'(q_reg[i]), 64'(i));
      check({tag, ".chk_actual"}, 64'(q_act[i]), 64'(rf[i]));
      check({tag, ".chk_expected"}, 64'(q_exp[i]), ver ? 64'(rom[i]) : 64'd0);
    end
    check({tag, ".error_count"}, 64'(error_count), ver ? 64'((cnt > 255) ? 255 : cnt) : 64'd0);
    check({tag, ".sat_error_count"}, 64'(s_error_count), ver ? 64'((cnt > 3) ? 3 : cnt) : 64'd0);
    check({tag, ".pass"}, 64'(pass), 64'(ver && cnt == 0));
    check({tag, ".sat_pass"}, 64'(s_pass), 64'(ver && cnt == 0));
    check({tag, ".fail_valid"}, 64'(fail_valid), 64'(ver && cnt > 0));
    check({tag, ".sat_fail_valid"}, 64'(s_fail_valid), 64'(ver && cnt > 0));
    check({tag, ".fail_reg"}, 64'(fail_reg), (ver && cnt > 0) ? 64'(first) : 64'd0);
    check({tag, ".sat_fail_reg"}, 64'(s_fail_reg), (ver && cnt > 0) ? 64'(first) : 64'd0);
    check({tag, ".sat_done"}, 64'(s_done), 64'd1);
    check({tag, ".done_idle_flags"}, 64'({busy, test_mode, run_en, s_busy, s_test_mode, s_run_en}), 64'd0);
    check({tag, ".sat_chk_idle"}, 64'({s_chk_valid, s_chk_reg, s_chk_actual, s_chk_expected}), 64'd0);
  endtask

  initial begin
    fill_match();
    proc_rs1 = AW'($urandom);
    @(negedge clock);
    @(negedge clock);
    check("reset.flags", 64'({run_en, test_mode, busy, done, pass, fail_valid, chk_valid}), 64'd0);
    check("reset.counts", 64'({error_count, fail_reg, chk_reg}), 64'd0);
    check("reset.chk_data", 64'({chk_actual, chk_expected}), 64'd0);
    check("reset.rf_rs1", 64'(rf_rs1), 64'(proc_rs1));
    check("reset.exp_addr", 64'(exp_addr), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_and_check(5, 1'b1, 1'b0, "match_n5");

    fill_match();
    rf[7] = 32'd3;  rom[7] = 32'd4;
    rf[20] = 32'd1; rom[20] = 32'd2;
    run_and_check(int'($urandom_range(1, 8)), 1'b1, 1'b0, "two_errors");

    fill_match();
    rom[3] = ~rf[3];
    run_and_check(0, 1'b1, 1'b0, "zero_cycles");

    for (int i = 0; i < NR; i++) rom[i] = ~rf[i];
    run_and_check(2, 1'b0, 1'b0, "dump_only");
    run_and_check(1, 1'b1, 1'b0, "all_mismatch");

    fill_match();
    rom[31] = rf[31] + 32'd1;
    run_and_check(6, 1'b1, 1'b1, "start_ignored");

    for (int r = 0; r < 3; r++) begin
      fill_match();
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 3) == 0) rom[i] = $urandom;
      run_and_check(int'($urandom_range(0, 10)), 1'($urandom), 1'b0, "random");
    end

    // Abort partway through SCAN
    fill_match();
    rom[1] = ~rf[1];
    num_cycles = 16'd3; verify_en = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 100 && test_mode !== 1'b1; c++) @(negedge clock);
    repeat (10) @(negedge clock);
    check("abort.scan_idx", 64'(rf_rs1), 64'd10);
    check("abort.err_before", 64'(error_count), 64'd1);
    proc_rs1 = AW'($urandom);
    reset = 1'b1;
    @(negedge clock);
    check("abort.flags", 64'({run_en, test_mode, busy, done, pass, fail_valid, chk_valid}), 64'd0);
    check("abort.counts", 64'({error_count, fail_reg, s_error_count}), 64'd0);
    check("abort.rf_rs1", 64'(rf_rs1), 64'(proc_rs1));
    reset = 1'b0;
    @(negedge clock);
    check("abort.stays_idle", 64'({busy, done, test_mode}), 64'd0);

    fill_match();
    rom[12] = rf[12] ^ 32'h0000_0100;
    run_and_check(4, 1'b1, 1'b0, "after_abort");
    fill_match();
    run_and_check(3, 1'b1, 1'b0, "restart_clean");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_verifier.md
Name: reg_verifier

Overview:
- Synthesizable self-check unit that replaces the bench-only register-check harness.
- Gates the processor for a programmed number of cycles, then takes over regfile read port A and sweeps every register.
- Compares each register against an expected-value ROM, counts mismatches and reports pass/fail.
- Sits between processor and regfile; generalised in data width, register count and cycle-count width, with a dump-only mode.

Parameters:
DATA_WIDTH, 32, register/expected data width
NUM_REGS, 32, registers swept (indices 0..NUM_REGS-1)
ADDR_WIDTH, 5, register index width; NUM_REGS <= 2**ADDR_WIDTH
CYCLE_WIDTH, 16, width of run-cycle counter
ERR_WIDTH, 8, error counter width; saturates

Ports:
clock  in  1  sole clock, all state updates on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  begin run; sampled only in IDLE or DONE
num_cycles  in  CYCLE_WIDTH  processor cycles to run; latched at start
verify_en  in  1  1 = compare, 0 = dump-only; latched at start
proc_rs1  in  ADDR_WIDTH  processor's regfile read-A index
rf_rs1  out  ADDR_WIDTH  index driven to regfile read-A (combinational mux)
rf_dataA  in  DATA_WIDTH  regfile read-A data (combinational read)
exp_addr  out  ADDR_WIDTH  expected-ROM address
exp_data  in  DATA_WIDTH  expected-ROM data, 1-cycle read latency
run_en  out  1  processor clock-enable
test_mode  out  1  high while sweeping
busy  out  1  high in RUN or SCAN
done  out  1  level, high in DONE
pass  out  1  valid when done: verify_en latched and error_count==0
error_count  out  ERR_WIDTH  mismatches, saturating
fail_valid  out  1  first mismatch captured
fail_reg  out  ADDR_WIDTH  index of first mismatch
chk_valid  out  1  one-cycle strobe per register checked/dumped
chk_reg  out  ADDR_WIDTH  register index for chk strobe
chk_actual  out  DATA_WIDTH  regfile value for chk strobe
chk_expected  out  DATA_WIDTH  ROM value for chk strobe (0 in dump-only)

Behaviour:
- Reset: state=IDLE; run_en, test_mode, busy, done, pass, fail_valid, chk_valid = 0; error_count, fail_reg, chk_* = 0; counters cleared. Reset mid-RUN/SCAN aborts immediately, no partial results kept.
- rf_rs1 = test_mode ? scan_idx : proc_rs1.
- IDLE/DONE + start=1 -> latch num_cycles and verify_en; clear error_count, fail_*; go to RUN (or to SCAN when num_cycles==0). start in RUN/SCAN is ignored.
- RUN: run_en=1 for exactly num_cycles cycles (counter 0..num_cycles-1), then SCAN. run_en=0 in every other state.
- SCAN cycle k (0..NUM_REGS-1): scan_idx=k, exp_addr=k, test_mode=1; capture rf_dataA and k into stage register.
- SCAN cycle k+1: exp_data for k valid; chk_valid=1 with chk_reg=k, chk_actual=captured value, chk_expected=exp_data (0 when verify_en=0).
- Compare (verify_en=1 only): mismatch increments error_count (held at 2**ERR_WIDTH-1). First mismatch sets fail_valid=1, fail_reg=k; later mismatches leave fail_reg unchanged.
- SCAN lasts NUM_REGS+1 cycles, the last being drain-only; then DONE.
- Register 0 is swept and compared like any other.
- DONE: done=1, pass valid; results held until start or reset. Restart from DONE clears results in the same edge as leaving DONE.
- exp_addr = 0 outside SCAN.

Test Plan:
- num_cycles=5, ROM matches regfile -> run_en high exactly 5 cycles; done 5+NUM_REGS+1 cycles after start; pass=1, error_count=0, 32 chk strobes with chk_reg 0..31.
- Regfile r7=3, ROM r7=4, r20=1 vs 2 -> error_count=2, fail_reg=7, fail_valid=1, pass=0.
- num_cycles=0 -> no run_en pulse; SCAN entered the cycle after start.
- verify_en=0 with mismatched ROM -> 32 chk strobes, chk_expected=0, error_count=0, pass=0.
- ERR_WIDTH=2, all 32 registers mismatch -> error_count saturates at 3.
- Reset asserted at SCAN cycle 10 -> next cycle IDLE, test_mode=0, rf_rs1 follows proc_rs1; start pulses during RUN are ignored; restart from DONE gives fresh results.
